// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the synthetic bouncy-button generator:
//   - FSM state encoding
//   - 16-bit Galois LFSR feedback mask (x^16+x^14+x^13+x^11+1) and default seed
//   - helpers for advancing the LFSR and sanitising the seed
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_BOUNCE = 2'd1,
    ST_HOLD         = 2'd2,
    ST_REL_BOUNCE   = 2'd3
  } btn_state_e;

  localparam logic [15:0] LFSR_POLY         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // One right-shifting Galois step: when the bit shifted out is 1 the
  // feedback mask is folded into the shifted value.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] r;
    r = {1'b0, s[15:1]};
    if (s[0]) begin
      r = r ^ LFSR_POLY;
    end else begin
      r = r;
    end
    return r;
  endfunction

  // An all-zero LFSR would lock up, so a zero seed becomes 1.
  function automatic logic [15:0] seed_fix(input logic [15:0] s);
    logic [15:0] r;
    if (s == 16'h0000) begin
      r = 16'h0001;
    end else begin
      r = s;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Produces a registered one-cycle strobe every CLK_DIV clock cycles. The
// internal counter runs 0..CLK_DIV-1 and the strobe is high in the cycle
// the counter holds CLK_DIV-1, so after a clear the first strobe is consumed
// exactly CLK_DIV edges later.
// Ports:
//   clk     in  system clock
//   reset   in  async active-low reset
//   i_clr   in  synchronous restart of the count at 0
//   o_tick  out one-cycle tick strobe (registered)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tick_gen #(
  parameter int unsigned CLK_DIV = 100_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLK_DIV - 2);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next-state: wrap or clear the counter, pre-decode the strobe one cycle early.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (i_clr) begin
      cnt_d  = '0;
      tick_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b0;
    end else begin
      cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      tick_d = (cnt_q == CNT_PRE);
    end
  end

  // Counter and strobe registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign o_tick = tick_q;

endmodule

// File: rtl/btn_bounce_gen.sv
// ---------------------------------------------------------------------------
// btn_bounce_gen
// Generates one synthetic press/release event of a mechanical button with
// pseudo-random contact bounce on both edges, for exercising debouncers.
// Event shape (in ticks): BOUNCE_TICKS of LFSR noise ending high, H ticks
// stable high, BOUNCE_TICKS of LFSR noise ending low, then o_done.
// Ports:
//   clk           in  system clock
//   reset         in  async active-low reset
//   i_start       in  request one event (accepted only in IDLE)
//   i_hold_ticks  in  stable-high duration in ticks (0 behaves as 1)
//   i_abort       in  force idle, outputs low, no o_done
//   o_btn         out synthetic button level (registered)
//   o_busy        out event in progress (registered)
//   o_done        out one-cycle completion pulse (registered)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module btn_bounce_gen
  import btn_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 100_000,
  parameter int unsigned BOUNCE_TICKS = 12,
  parameter logic [15:0] LFSR_SEED    = LFSR_SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_hold_ticks,
  input  logic       i_abort,
  output logic       o_btn,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [15:0] SEED_EFF = seed_fix(LFSR_SEED);
  localparam logic [7:0]  BNC_LOAD = 8'(BOUNCE_TICKS);

  btn_state_e  state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  bnc_q, bnc_d;
  logic [7:0]  hold_lat_q, hold_lat_d;
  logic [7:0]  hold_q, hold_d;
  logic        btn_q, btn_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tick_s;
  logic        tick_clr_s;

  tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (tick_clr_s),
    .o_tick (tick_s)
  );

  // FSM next-state, counters, LFSR and output decode.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    bnc_d      = bnc_q;
    hold_lat_d = hold_lat_q;
    hold_d     = hold_q;
    btn_d      = btn_q;
    done_d     = 1'b0;
    tick_clr_s = 1'b0;

    if (i_abort) begin
      // Abort beats everything, including a simultaneous start; LFSR is kept.
      state_d    = ST_IDLE;
      btn_d      = 1'b0;
      bnc_d      = 8'd0;
      hold_d     = 8'd0;
      tick_clr_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          btn_d = 1'b0;
          if (i_start) begin
            tick_clr_s = 1'b1;
            hold_lat_d = (i_hold_ticks == 8'd0) ? 8'd1 : i_hold_ticks;
            bnc_d      = BNC_LOAD;
            state_d    = ST_PRESS_BOUNCE;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_PRESS_BOUNCE: begin
          if (tick_s) begin
            btn_d  = lfsr_q[0];
            lfsr_d = lfsr_step(lfsr_q);
            bnc_d  = bnc_q - 8'd1;
            // Last bounce tick settles the contact closed.
            if (bnc_q == 8'd1) begin
              btn_d   = 1'b1;
              hold_d  = hold_lat_q;
              state_d = ST_HOLD;
            end else begin
              state_d = ST_PRESS_BOUNCE;
            end
          end else begin
            state_d = ST_PRESS_BOUNCE;
          end
        end

        ST_HOLD: begin
          btn_d = 1'b1;
          if (tick_s) begin
            hold_d = hold_q - 8'd1;
            if (hold_q == 8'd1) begin
              bnc_d   = BNC_LOAD;
              state_d = ST_REL_BOUNCE;
            end else begin
              state_d = ST_HOLD;
            end
          end else begin
            state_d = ST_HOLD;
          end
        end

        ST_REL_BOUNCE: begin
          // A zero count here means o_done is being presented this cycle;
          // staying one extra cycle out of IDLE makes a start coincident
          // with o_done get ignored rather than accepted.
          if (bnc_q == 8'd0) begin
            state_d = ST_IDLE;
          end else if (tick_s) begin
            btn_d  = lfsr_q[0];
            lfsr_d = lfsr_step(lfsr_q);
            bnc_d  = bnc_q - 8'd1;
            if (bnc_q == 8'd1) begin
              btn_d  = 1'b0;
              done_d = 1'b1;
            end else begin
              done_d = 1'b0;
            end
          end else begin
            state_d = ST_REL_BOUNCE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          btn_d   = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= SEED_EFF;
      bnc_q      <= 8'd0;
      hold_lat_q <= 8'd0;
      hold_q     <= 8'd0;
      btn_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      bnc_q      <= bnc_d;
      hold_lat_q <= hold_lat_d;
      hold_q     <= hold_d;
      btn_q      <= btn_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_btn  = btn_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_btn_bounce_gen.sv
// ---------------------------------------------------------------------------
// tb_btn_bounce_gen
// Directed bench for btn_bounce_gen with CLK_DIV=4, BOUNCE_TICKS=3,
// seed 16'hACE1. Expected levels come from a tick-count model of the event
// shape and an independent Galois LFSR reference.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_btn_bounce_gen;

  localparam int D = 4;
  localparam int B = 3;

  logic       clk;
  logic       reset;
  logic       i_start;
  logic [7:0] i_hold_ticks;
  logic       i_abort;
  logic       o_btn;
  logic       o_busy;
  logic       o_done;

  int          total;
  int          bad;
  logic [15:0] m_lfsr;

  btn_bounce_gen #(
    .CLK_DIV      (D),
    .BOUNCE_TICKS (B),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_hold_ticks (i_hold_ticks),
    .i_abort      (i_abort),
    .o_btn        (o_btn),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0] == 1'b1) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({o_btn, o_busy, o_done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_outputs: got btn/busy/done=%b expected 000", {o_btn, o_busy, o_done});
    end
    reset = 1'b1;
    m_lfsr = 16'hACE1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({o_btn, o_busy, o_done} !== 3'b000) begin
      bad++;
      $display("FAIL post_reset_idle: got %b expected 000", {o_btn, o_busy, o_done});
    end
  endtask

  // Full event with cycle-exact checks. mode 1: extra start mid-event,
  // mode 2: start presented in the o_done cycle.
  task automatic test_event_timing(input int h, input int mode);
    int heff, t_len, k, ndone;
    logic [15:0] s [0:5];
    logic e;
    heff  = (h == 0) ? 1 : h;
    t_len = (2 * B + heff) * D;
    s[0] = m_lfsr;
    for (int i = 1; i < 6; i++) s[i] = ref_step(s[i-1]);

    i_hold_ticks = 8'(h);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_hold_ticks = 8'd200;
    total++;
    if (o_busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_accept h=%0d: got %b expected 1", h, o_busy);
    end

    ndone = 0;
    for (int n = 1; n <= t_len + 1; n++) begin
      i_start = ((mode == 1) && (n == 10)) || ((mode == 2) && (n == t_len + 1));
      @(posedge clk);
      #1;
      i_start = 1'b0;
      k = n / D;
      if (k == 0)                e = 1'b0;
      else if (k < B)            e = s[k-1][0];
      else if (k <= B + heff)    e = 1'b1;
      else if (k < 2*B + heff)   e = s[B + k - (B + heff + 1)][0];
      else                       e = 1'b0;
      total++;
      if (o_btn !== e) begin
        bad++;
        $display("FAIL btn_level h=%0d cyc=%0d: got %b expected %b", h, n, o_btn, e);
      end
      total++;
      if (o_busy !== (n <= t_len)) begin
        bad++;
        $display("FAIL busy_level h=%0d cyc=%0d: got %b expected %b", h, n, o_busy, (n <= t_len));
      end
      total++;
      if (o_done !== (n == t_len)) begin
        bad++;
        $display("FAIL done_timing h=%0d cyc=%0d: got %b expected %b", h, n, o_done, (n == t_len));
      end
      if (o_done === 1'b1) ndone++;
    end

    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (o_done === 1'b1) ndone++;
      total++;
      if (o_busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_after_event h=%0d cyc=%0d: got busy=%b expected 0", h, n, o_busy);
      end
    end
    total++;
    if (ndone != 1) begin
      bad++;
      $display("FAIL done_count h=%0d: got %0d expected 1", h, ndone);
    end
    m_lfsr = ref_step(s[5]);
  endtask

  task automatic test_abort_hold();
    i_hold_ticks = 8'd5;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    total++;
    if (o_btn !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre_hold: got btn=%b expected 1", o_btn);
    end
    i_abort = 1'b1;
    @(posedge clk);
    #1;
    i_abort = 1'b0;
    total++;
    if ({o_btn, o_busy, o_done} !== 3'b000) begin
      bad++;
      $display("FAIL abort_outputs: got %b expected 000", {o_btn, o_busy, o_done});
    end
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      #1;
      total++;
      if ({o_busy, o_done} !== 2'b00) begin
        bad++;
        $display("FAIL abort_stays_idle cyc=%0d: got busy/done=%b expected 00", n, {o_busy, o_done});
      end
    end
    // Three press-bounce ticks consumed LFSR states before the abort.
    for (int i = 0; i < 3; i++) m_lfsr = ref_step(m_lfsr);
  endtask

  task automatic test_start_abort();
    i_hold_ticks = 8'd5;
    i_start = 1'b1;
    i_abort = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_abort = 1'b0;
    for (int n = 0; n < 8; n++) begin
      total++;
      if (o_busy !== 1'b0) begin
        bad++;
        $display("FAIL start_abort_busy cyc=%0d: got %b expected 0", n, o_busy);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    i_hold_ticks = 8'd2;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (26) @(posedge clk);
    #1;
    total++;
    if (o_busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_pre_busy: got %b expected 1", o_busy);
    end
    #3;
    reset = 1'b0;
    #1;
    total++;
    if ({o_btn, o_busy, o_done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_mid_async: got %b expected 000", {o_btn, o_busy, o_done});
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    m_lfsr = 16'hACE1;
    ndone = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (o_done === 1'b1) ndone++;
    end
    total++;
    if ((ndone != 0) || (o_busy !== 1'b0)) begin
      bad++;
      $display("FAIL reset_mid_no_done: got done_count=%0d busy=%b expected 0 0", ndone, o_busy);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_hold_ticks = 8'd0;
    m_lfsr = 16'hACE1;

    test_reset();
    test_event_timing(5, 0);
    test_event_timing(0, 1);
    test_event_timing(1, 2);
    test_abort_hold();
    test_event_timing(2, 0);
    test_start_abort();
    test_reset_mid();
    test_event_timing(5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
